// File: rtl/arm_pkg.sv
// Shared ARM control definitions: condition-code encoding and NZCV flag bit positions.
package arm_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    localparam logic [1:0] N = 2'd3;
    localparam logic [1:0] Z = 2'd2;
    localparam logic [1:0] C = 2'd1;
    localparam logic [1:0] V = 2'd0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: decides whether an instruction's Cond passes against the flags.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = Flags[N];
    assign z_s = Flags[Z];
    assign c_s = Flags[C];
    assign v_s = Flags[V];

    // Condition table lookup
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            EQ:      CondEx = z_s;
            NE:      CondEx = ~z_s;
            CS:      CondEx = c_s;
            CC:      CondEx = ~c_s;
            MI:      CondEx = n_s;
            PL:      CondEx = ~n_s;
            VS:      CondEx = v_s;
            VC:      CondEx = ~v_s;
            HI:      CondEx = c_s & ~z_s;
            LS:      CondEx = ~c_s | z_s;
            GE:      CondEx = (n_s == v_s);
            LT:      CondEx = (n_s != v_s);
            GT:      CondEx = ~z_s & (n_s == v_s);
            LE:      CondEx = z_s | (n_s != v_s);
            AL:      CondEx = 1'b1;
            NV:      CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_pipeline.sv
// E/M/W control pipeline for a pipelined ARM core: conditional execution gating and the NZCV flags register.
module control_pipeline
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       FlushE,
    input  logic       PCSD,
    input  logic       RegWD,
    input  logic       MemWD,
    input  logic       MemtoRegD,
    input  logic       ALUSrcD,
    input  logic [1:0] FlagWD,
    input  logic [2:0] ALUControlD,
    input  logic [3:0] CondD,
    input  logic [3:0] ALUFlags,
    output logic [2:0] ALUControlE,
    output logic       ALUSrcE,
    output logic [3:0] FlagsE,
    output logic       CondExE,
    output logic       PCSrcE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       MemtoRegE,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic       MemtoRegM,
    output logic       PCSrcW,
    output logic       RegWriteW,
    output logic       MemtoRegW
);

    logic       pcs_e_r;
    logic       regw_e_r;
    logic       memw_e_r;
    logic       memtoreg_e_r;
    logic       alusrc_e_r;
    logic [1:0] flagw_e_r;
    logic [2:0] aluctl_e_r;
    logic [3:0] cond_e_r;
    logic [3:0] flags_r;
    logic       condex_s;

    cond_check u_cond_check (
        .Cond   (cond_e_r),
        .Flags  (flags_r),
        .CondEx (condex_s)
    );

    // D->E control register; a flush loads an always-pass bubble with no side effects
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcs_e_r      <= 1'b0;
            regw_e_r     <= 1'b0;
            memw_e_r     <= 1'b0;
            memtoreg_e_r <= 1'b0;
            alusrc_e_r   <= 1'b0;
            flagw_e_r    <= 2'b00;
            aluctl_e_r   <= 3'b000;
            cond_e_r     <= AL;
        end else if (FlushE) begin
            pcs_e_r      <= 1'b0;
            regw_e_r     <= 1'b0;
            memw_e_r     <= 1'b0;
            memtoreg_e_r <= 1'b0;
            alusrc_e_r   <= 1'b0;
            flagw_e_r    <= 2'b00;
            aluctl_e_r   <= 3'b000;
            cond_e_r     <= AL;
        end else begin
            pcs_e_r      <= PCSD;
            regw_e_r     <= RegWD;
            memw_e_r     <= MemWD;
            memtoreg_e_r <= MemtoRegD;
            alusrc_e_r   <= ALUSrcD;
            flagw_e_r    <= FlagWD;
            aluctl_e_r   <= ALUControlD;
            cond_e_r     <= CondD;
        end
    end

    // Flags written at the end of E so the very next instruction sees them; flush does not cancel this
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= 4'b0000;
        end else begin
            if (flagw_e_r[1] && condex_s) begin
                flags_r[3:2] <= ALUFlags[3:2];
            end else begin
                flags_r[3:2] <= flags_r[3:2];
            end
            if (flagw_e_r[0] && condex_s) begin
                flags_r[1:0] <= ALUFlags[1:0];
            end else begin
                flags_r[1:0] <= flags_r[1:0];
            end
        end
    end

    // E->M and M->W carry already-gated enables, so a failed condition travels as a no-op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else begin
            PCSrcM    <= PCSrcE;
            RegWriteM <= RegWriteE;
            MemWriteM <= MemWriteE;
            MemtoRegM <= MemtoRegE;
            PCSrcW    <= PCSrcM;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
        end
    end

    assign CondExE     = condex_s;
    assign FlagsE      = flags_r;
    assign ALUControlE = aluctl_e_r;
    assign ALUSrcE     = alusrc_e_r;
    assign PCSrcE      = pcs_e_r & condex_s;
    assign RegWriteE   = regw_e_r & condex_s;
    assign MemWriteE   = memw_e_r & condex_s;
    assign MemtoRegE   = memtoreg_e_r;

endmodule
